// File: rtl/exec_queue_pkg.sv
// Shared core definitions for the execute-to-memory queue: payload layout,
// register/CSR widths and the per-entry control record.
package exec_queue_pkg;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned REG_AW = 5;
   localparam int unsigned CSR_AW = 12;

   localparam logic [REG_AW-1:0] REG_X0 = 5'd0;

   // Opaque payload composition, LSB first
   localparam int unsigned MR_ADDR_OFF   = 0;
   localparam int unsigned MR_ADDR_W     = 32;
   localparam int unsigned MR_STRB_OFF   = MR_ADDR_OFF + MR_ADDR_W;
   localparam int unsigned MR_STRB_W     = 4;
   localparam int unsigned MR_SIGNED_OFF = MR_STRB_OFF + MR_STRB_W;
   localparam int unsigned MR_SIGNED_W   = 1;
   localparam int unsigned MW_EN_OFF     = MR_SIGNED_OFF + MR_SIGNED_W;
   localparam int unsigned MW_EN_W       = 1;
   localparam int unsigned MW_ADDR_OFF   = MW_EN_OFF + MW_EN_W;
   localparam int unsigned MW_ADDR_W     = 32;
   localparam int unsigned MW_STRB_OFF   = MW_ADDR_OFF + MW_ADDR_W;
   localparam int unsigned MW_STRB_W     = 4;
   localparam int unsigned MW_DATA_OFF   = MW_STRB_OFF + MW_STRB_W;
   localparam int unsigned MW_DATA_W     = 32;
   localparam int unsigned JMP_DO_OFF    = MW_DATA_OFF + MW_DATA_W;
   localparam int unsigned JMP_DO_W      = 1;
   localparam int unsigned JMP_PC_OFF    = JMP_DO_OFF + JMP_DO_W;
   localparam int unsigned JMP_PC_W      = 32;
   localparam int unsigned RSVD_OFF      = JMP_PC_OFF + JMP_PC_W;
   localparam int unsigned RSVD_W        = 6;
   localparam int unsigned PAYLOAD_W     = RSVD_OFF + RSVD_W;

   typedef struct packed {
      logic              reg_w_en;
      logic [REG_AW-1:0] reg_w_rd;
      logic [XLEN-1:0]   reg_w_data;
      logic              csr_w_en;
      logic [CSR_AW-1:0] csr_w_addr;
      logic [XLEN-1:0]   csr_w_data;
      logic              mem_r_en;
      logic [REG_AW-1:0] mem_r_rd;
   } exec_ctl_t;

endpackage

// File: rtl/exec_queue_lookup.sv
// Newest-first priority search over the occupied window [head, head+count).
// A load match in the winning entry reports busy instead of hit.
module exec_queue_lookup #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = 5,
   parameter int unsigned PTR_W = 2,
   parameter int unsigned CNT_W = 3
) (
   input  logic [DEPTH-1:0]         valid,
   input  logic [DEPTH-1:0]         w_en,
   input  logic [DEPTH-1:0][AW-1:0] w_addr,
   input  logic [DEPTH-1:0]         ld_en,
   input  logic [DEPTH-1:0][AW-1:0] ld_addr,
   input  logic [AW-1:0]            query,
   input  logic [PTR_W-1:0]         head,
   input  logic [CNT_W-1:0]         count,
   output logic                     hit,
   output logic                     busy,
   output logic [PTR_W-1:0]         index
);

   localparam int unsigned SW = PTR_W + 1;

   logic [SW-1:0]    sum;
   logic [PTR_W-1:0] slot;

   // Walk oldest to newest so the last match seen is the newest one
   always_comb begin
      hit   = 1'b0;
      busy  = 1'b0;
      index = '0;
      sum   = '0;
      slot  = '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         sum = SW'(head) + SW'(k);
         if (sum >= SW'(DEPTH)) sum = sum - SW'(DEPTH);
         slot = sum[PTR_W-1:0];
         if ((CNT_W'(k) < count) && valid[slot]) begin
            if (ld_en[slot] && (ld_addr[slot] == query)) begin
               hit   = 1'b0;
               busy  = 1'b1;
               index = slot;
            end else if (w_en[slot] && (w_addr[slot] == query)) begin
               hit   = 1'b1;
               busy  = 1'b0;
               index = slot;
            end
         end
      end
   end

endmodule

// File: rtl/exec_queue.sv
// DEPTH-entry in-order queue between execute and memory-read, with
// newest-first register/CSR forwarding over all buffered entries.
module exec_queue
   import exec_queue_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned PW    = PAYLOAD_W
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic                         FLUSH,
   input  logic                         MEM_WAIT,
   input  logic                         EXEC_VALID,
   output logic                         IN_READY,
   input  logic                         EXEC_REG_W_EN,
   input  logic [4:0]                   EXEC_REG_W_RD,
   input  logic [31:0]                  EXEC_REG_W_DATA,
   input  logic                         EXEC_CSR_W_EN,
   input  logic [11:0]                  EXEC_CSR_W_ADDR,
   input  logic [31:0]                  EXEC_CSR_W_DATA,
   input  logic                         EXEC_MEM_R_EN,
   input  logic [4:0]                   EXEC_MEM_R_RD,
   input  logic [PW-1:0]                EXEC_PAYLOAD,
   output logic                         OUT_VALID,
   output logic                         Q_REG_W_EN,
   output logic [4:0]                   Q_REG_W_RD,
   output logic [31:0]                  Q_REG_W_DATA,
   output logic                         Q_CSR_W_EN,
   output logic [11:0]                  Q_CSR_W_ADDR,
   output logic [31:0]                  Q_CSR_W_DATA,
   output logic                         Q_MEM_R_EN,
   output logic [4:0]                   Q_MEM_R_RD,
   output logic [PW-1:0]                Q_PAYLOAD,
   output logic [$clog2(DEPTH+1)-1:0]   COUNT,
   input  logic [4:0]                   FWD_REG_ADDR,
   output logic                         FWD_REG_HIT,
   output logic                         FWD_REG_BUSY,
   output logic [31:0]                  FWD_REG_DATA,
   input  logic [11:0]                  FWD_CSR_ADDR,
   output logic                         FWD_CSR_HIT,
   output logic [31:0]                  FWD_CSR_DATA
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [PTR_W-1:0] head, tail;
   logic [CNT_W-1:0] count;
   logic [DEPTH-1:0] valid;
   exec_ctl_t        ctl_mem [DEPTH];
   logic [PW-1:0]    pay_mem [DEPTH];
   exec_ctl_t        exec_ctl, head_ctl;
   logic             enq, deq;

   logic [DEPTH-1:0]              reg_en_v, ld_en_v, csr_en_v;
   logic [DEPTH-1:0][REG_AW-1:0]  rd_v, ld_rd_v;
   logic [DEPTH-1:0][CSR_AW-1:0]  csr_v;
   logic                          reg_hit, reg_busy, csr_hit, csr_busy, reg_q_ok;
   logic [PTR_W-1:0]              reg_idx, csr_idx;

   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign IN_READY  = (count < CNT_W'(DEPTH));
   assign OUT_VALID = (count != '0);
   assign COUNT     = count;
   assign enq       = EXEC_VALID && IN_READY && !FLUSH;
   assign deq       = OUT_VALID && !MEM_WAIT && !FLUSH;

   // Pointers, occupancy and valid bits; storage itself is never reset
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         valid <= '0;
      end else if (FLUSH) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         valid <= '0;
      end else begin
         if (enq) begin
            valid[tail] <= 1'b1;
            tail        <= ptr_next(tail);
         end
         if (deq) begin
            valid[head] <= 1'b0;
            head        <= ptr_next(head);
         end
         if (enq && !deq)      count <= count + CNT_W'(1);
         else if (deq && !enq) count <= count - CNT_W'(1);
      end
   end

   assign exec_ctl = '{reg_w_en:   EXEC_REG_W_EN,   reg_w_rd:   EXEC_REG_W_RD,
                       reg_w_data: EXEC_REG_W_DATA, csr_w_en:   EXEC_CSR_W_EN,
                       csr_w_addr: EXEC_CSR_W_ADDR, csr_w_data: EXEC_CSR_W_DATA,
                       mem_r_en:   EXEC_MEM_R_EN,   mem_r_rd:   EXEC_MEM_R_RD};

   always_ff @(posedge CLK) begin
      if (enq) begin
         ctl_mem[tail] <= exec_ctl;
         pay_mem[tail] <= EXEC_PAYLOAD;
      end
   end

   // Head fields are masked to zero while empty
   assign head_ctl     = OUT_VALID ? ctl_mem[head] : '0;
   assign Q_PAYLOAD    = OUT_VALID ? pay_mem[head] : '0;
   assign Q_REG_W_EN   = head_ctl.reg_w_en;
   assign Q_REG_W_RD   = head_ctl.reg_w_rd;
   assign Q_REG_W_DATA = head_ctl.reg_w_data;
   assign Q_CSR_W_EN   = head_ctl.csr_w_en;
   assign Q_CSR_W_ADDR = head_ctl.csr_w_addr;
   assign Q_CSR_W_DATA = head_ctl.csr_w_data;
   assign Q_MEM_R_EN   = head_ctl.mem_r_en;
   assign Q_MEM_R_RD   = head_ctl.mem_r_rd;

   always_comb begin
      reg_en_v = '0;
      ld_en_v  = '0;
      csr_en_v = '0;
      rd_v     = '0;
      ld_rd_v  = '0;
      csr_v    = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         reg_en_v[i] = ctl_mem[i].reg_w_en;
         rd_v[i]     = ctl_mem[i].reg_w_rd;
         ld_en_v[i]  = ctl_mem[i].mem_r_en;
         ld_rd_v[i]  = ctl_mem[i].mem_r_rd;
         csr_en_v[i] = ctl_mem[i].csr_w_en;
         csr_v[i]    = ctl_mem[i].csr_w_addr;
      end
   end

   exec_queue_lookup #(.DEPTH(DEPTH), .AW(REG_AW), .PTR_W(PTR_W), .CNT_W(CNT_W)) u_reg_lookup (
      .valid(valid), .w_en(reg_en_v), .w_addr(rd_v), .ld_en(ld_en_v), .ld_addr(ld_rd_v),
      .query(FWD_REG_ADDR), .head(head), .count(count),
      .hit(reg_hit), .busy(reg_busy), .index(reg_idx));

   exec_queue_lookup #(.DEPTH(DEPTH), .AW(CSR_AW), .PTR_W(PTR_W), .CNT_W(CNT_W)) u_csr_lookup (
      .valid(valid), .w_en(csr_en_v), .w_addr(csr_v), .ld_en('0), .ld_addr('0),
      .query(FWD_CSR_ADDR), .head(head), .count(count),
      .hit(csr_hit), .busy(csr_busy), .index(csr_idx));

   // x0 is hard-wired zero and never forwarded or stalled on
   assign reg_q_ok     = (FWD_REG_ADDR != REG_X0);
   assign FWD_REG_HIT  = reg_q_ok && reg_hit;
   assign FWD_REG_BUSY = reg_q_ok && reg_busy;
   assign FWD_REG_DATA = FWD_REG_HIT ? ctl_mem[reg_idx].reg_w_data : '0;
   assign FWD_CSR_HIT  = csr_hit && !csr_busy;
   assign FWD_CSR_DATA = FWD_CSR_HIT ? ctl_mem[csr_idx].csr_w_data : '0;

endmodule

// File: tb/tb_exec_queue.sv
// Directed plus random bench for exec_queue at DEPTH=4 and DEPTH=3, compared
// against a queue-based reference model of the queue and forwarding rules.
module tb_exec_queue;

   typedef struct packed {
      logic         reg_w_en;
      logic [4:0]   rd;
      logic [31:0]  rdata;
      logic         csr_en;
      logic [11:0]  caddr;
      logic [31:0]  cdata;
      logic         ld_en;
      logic [4:0]   ld_rd;
      logic [144:0] pay;
   } ent_t;

   logic        clk, rst, flush, mem_wait, exec_valid;
   ent_t        cur;
   logic [4:0]  fwd_reg_addr;
   logic [11:0] fwd_csr_addr;

   logic        in_ready_a, out_valid_a, frh_a, frb_a, fch_a;
   logic [31:0] frd_a, fcd_a;
   logic [2:0]  count_a;
   ent_t        hd_a;
   logic        in_ready_b, out_valid_b, frh_b, frb_b, fch_b;
   logic [31:0] frd_b, fcd_b;
   logic [1:0]  count_b;
   ent_t        hd_b;

   ent_t qa[$];
   ent_t qb[$];
   int   checks = 0;
   int   errors = 0;

   exec_queue #(.DEPTH(4)) u_dut_a (
      .CLK(clk), .RST(rst), .FLUSH(flush), .MEM_WAIT(mem_wait), .EXEC_VALID(exec_valid),
      .IN_READY(in_ready_a),
      .EXEC_REG_W_EN(cur.reg_w_en), .EXEC_REG_W_RD(cur.rd), .EXEC_REG_W_DATA(cur.rdata),
      .EXEC_CSR_W_EN(cur.csr_en), .EXEC_CSR_W_ADDR(cur.caddr), .EXEC_CSR_W_DATA(cur.cdata),
      .EXEC_MEM_R_EN(cur.ld_en), .EXEC_MEM_R_RD(cur.ld_rd), .EXEC_PAYLOAD(cur.pay),
      .OUT_VALID(out_valid_a),
      .Q_REG_W_EN(hd_a.reg_w_en), .Q_REG_W_RD(hd_a.rd), .Q_REG_W_DATA(hd_a.rdata),
      .Q_CSR_W_EN(hd_a.csr_en), .Q_CSR_W_ADDR(hd_a.caddr), .Q_CSR_W_DATA(hd_a.cdata),
      .Q_MEM_R_EN(hd_a.ld_en), .Q_MEM_R_RD(hd_a.ld_rd), .Q_PAYLOAD(hd_a.pay),
      .COUNT(count_a),
      .FWD_REG_ADDR(fwd_reg_addr), .FWD_REG_HIT(frh_a), .FWD_REG_BUSY(frb_a), .FWD_REG_DATA(frd_a),
      .FWD_CSR_ADDR(fwd_csr_addr), .FWD_CSR_HIT(fch_a), .FWD_CSR_DATA(fcd_a));

   exec_queue #(.DEPTH(3)) u_dut_b (
      .CLK(clk), .RST(rst), .FLUSH(flush), .MEM_WAIT(mem_wait), .EXEC_VALID(exec_valid),
      .IN_READY(in_ready_b),
      .EXEC_REG_W_EN(cur.reg_w_en), .EXEC_REG_W_RD(cur.rd), .EXEC_REG_W_DATA(cur.rdata),
      .EXEC_CSR_W_EN(cur.csr_en), .EXEC_CSR_W_ADDR(cur.caddr), .EXEC_CSR_W_DATA(cur.cdata),
      .EXEC_MEM_R_EN(cur.ld_en), .EXEC_MEM_R_RD(cur.ld_rd), .EXEC_PAYLOAD(cur.pay),
      .OUT_VALID(out_valid_b),
      .Q_REG_W_EN(hd_b.reg_w_en), .Q_REG_W_RD(hd_b.rd), .Q_REG_W_DATA(hd_b.rdata),
      .Q_CSR_W_EN(hd_b.csr_en), .Q_CSR_W_ADDR(hd_b.caddr), .Q_CSR_W_DATA(hd_b.cdata),
      .Q_MEM_R_EN(hd_b.ld_en), .Q_MEM_R_RD(hd_b.ld_rd), .Q_PAYLOAD(hd_b.pay),
      .COUNT(count_b),
      .FWD_REG_ADDR(fwd_reg_addr), .FWD_REG_HIT(frh_b), .FWD_REG_BUSY(frb_b), .FWD_REG_DATA(frd_b),
      .FWD_CSR_ADDR(fwd_csr_addr), .FWD_CSR_HIT(fch_b), .FWD_CSR_DATA(fcd_b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference forwarding: scan from newest to oldest, first match wins
   task automatic fwd_model(input ent_t q[$], input logic [4:0] ra, input logic [11:0] ca,
                            output logic rh, output logic rb, output logic [31:0] rd,
                            output logic ch, output logic [31:0] cd);
      bit done_r, done_c;
      rh = 0; rb = 0; rd = '0; ch = 0; cd = '0; done_r = 0; done_c = 0;
      for (int i = q.size() - 1; i >= 0; i--) begin
         if (!done_r && ra != 5'd0) begin
            if (q[i].ld_en && q[i].ld_rd == ra) begin
               rb = 1; done_r = 1;
            end else if (q[i].reg_w_en && q[i].rd == ra) begin
               rh = 1; rd = q[i].rdata; done_r = 1;
            end
         end
         if (!done_c && q[i].csr_en && q[i].caddr == ca) begin
            ch = 1; cd = q[i].cdata; done_c = 1;
         end
      end
   endtask

   task automatic check_dut(input string nm, input ent_t q[$], input int d,
                            input logic ir, input logic ov, input logic [2:0] cnt, input ent_t hd,
                            input logic frh, input logic frb, input logic [31:0] frd,
                            input logic fch, input logic [31:0] fcd);
      ent_t        eh;
      logic        rh, rb, ch;
      logic [31:0] rd, cd;
      eh = (q.size() > 0) ? q[0] : '0;
      fwd_model(q, fwd_reg_addr, fwd_csr_addr, rh, rb, rd, ch, cd);
      chk({nm, "_count"},    256'(cnt), 256'(q.size()));
      chk({nm, "_in_ready"}, 256'(ir),  256'(q.size() < d));
      chk({nm, "_out_valid"},256'(ov),  256'(q.size() > 0));
      chk({nm, "_head"},     256'(hd),  256'(eh));
      chk({nm, "_reg_hit"},  256'(frh), 256'(rh));
      chk({nm, "_reg_busy"}, 256'(frb), 256'(rb));
      chk({nm, "_reg_data"}, 256'(frd), 256'(rd));
      chk({nm, "_csr_hit"},  256'(fch), 256'(ch));
      chk({nm, "_csr_data"}, 256'(fcd), 256'(cd));
   endtask

   task automatic check_all();
      check_dut("A", qa, 4, in_ready_a, out_valid_a, count_a, hd_a, frh_a, frb_a, frd_a, fch_a, fcd_a);
      check_dut("B", qb, 3, in_ready_b, out_valid_b, {1'b0, count_b}, hd_b, frh_b, frb_b, frd_b, fch_b, fcd_b);
   endtask

   task automatic step_models();
      bit ea, da, eb, db;
      if (flush) begin
         qa.delete();
         qb.delete();
      end else begin
         ea = exec_valid && (qa.size() < 4);
         da = (qa.size() > 0) && !mem_wait;
         eb = exec_valid && (qb.size() < 3);
         db = (qb.size() > 0) && !mem_wait;
         if (da) void'(qa.pop_front());
         if (ea) qa.push_back(cur);
         if (db) void'(qb.pop_front());
         if (eb) qb.push_back(cur);
      end
   endtask

   task automatic tick();
      step_models();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic rand_ent();
      cur.reg_w_en = 1'($urandom);
      cur.rd       = 5'($urandom_range(0, 7));
      cur.rdata    = $urandom;
      cur.csr_en   = 1'($urandom);
      cur.caddr    = 12'h300 + 12'($urandom_range(0, 3));
      cur.cdata    = $urandom;
      cur.ld_en    = ($urandom_range(0, 3) == 0);
      cur.ld_rd    = 5'($urandom_range(0, 7));
      cur.pay      = 145'({$urandom, $urandom, $urandom, $urandom, $urandom});
   endtask

   initial begin
      logic [31:0] seq[$];
      int          acc;
      bit          ok_b;

      rst = 1; flush = 0; mem_wait = 0; exec_valid = 0; cur = '0;
      fwd_reg_addr = 5'd1; fwd_csr_addr = 12'h300;
      #2;
      check_all();
      chk("reset_in_ready", 256'(in_ready_a), 256'(1));
      @(posedge clk); #1;
      rst = 0;

      // Fill DEPTH=4 under MEM_WAIT, then a fifth request that must be refused
      mem_wait = 1;
      for (int i = 0; i < 5; i++) begin
         rand_ent();
         cur.reg_w_en = 1; cur.rd = 5'(i + 1); cur.rdata = 32'h100 + 32'(i);
         exec_valid = 1;
         tick();
      end
      chk("fill_count", 256'(count_a), 256'(4));
      chk("fill_ready", 256'(in_ready_a), 256'(0));

      // Drain in order
      exec_valid = 0; mem_wait = 0;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("drain_%0d", i), 256'(hd_a.rdata), 256'(32'h100 + 32'(i)));
         tick();
      end
      chk("drain_empty", 256'(count_a), 256'(0));

      // Wrap-around on DEPTH=3: 7 items through, dequeues interleaved
      acc = 0;
      rand_ent(); cur.rdata = 32'h200;
      for (int cyc = 0; cyc < 60; cyc++) begin
         mem_wait   = (cyc % 2 == 1);
         exec_valid = (acc < 7);
         if (out_valid_b && !mem_wait) seq.push_back(hd_b.rdata);
         ok_b = exec_valid && (qb.size() < 3);
         tick();
         if (ok_b) begin
            acc++;
            rand_ent(); cur.rdata = 32'h200 + 32'(acc);
         end
         if (acc == 7 && qb.size() == 0) break;
      end
      chk("wrap_len", 256'(seq.size()), 256'(7));
      for (int i = 0; i < 7; i++)
         chk($sformatf("wrap_seq_%0d", i), 256'(seq[i]), 256'(32'h200 + 32'(i)));

      // Forwarding priority: newer write wins, then a newer load makes it busy
      exec_valid = 0; flush = 1; tick(); flush = 0;
      mem_wait = 1; exec_valid = 1;
      cur = '0; cur.reg_w_en = 1; cur.rd = 5'd5; cur.rdata = 32'h11; tick();
      cur.rdata = 32'h22; tick();
      exec_valid = 0; fwd_reg_addr = 5'd5; #1;
      chk("fwd_hit", 256'(frh_a), 256'(1));
      chk("fwd_data", 256'(frd_a), 256'(32'h22));
      cur = '0; cur.ld_en = 1; cur.ld_rd = 5'd5; exec_valid = 1; tick();
      exec_valid = 0; #1;
      chk("fwd_load_busy", 256'(frb_a), 256'(1));
      chk("fwd_load_hit", 256'(frh_a), 256'(0));
      chk("fwd_load_busy_b", 256'(frb_b), 256'(1));

      // x0 never forwards; CSR write forwards
      flush = 1; tick(); flush = 0;
      exec_valid = 1;
      cur = '0; cur.reg_w_en = 1; cur.rd = 5'd0; cur.rdata = 32'hFF; tick();
      cur = '0; cur.csr_en = 1; cur.caddr = 12'h300; cur.cdata = 32'hABCD; tick();
      exec_valid = 0; fwd_reg_addr = 5'd0; fwd_csr_addr = 12'h300; #1;
      chk("x0_hit", 256'(frh_a), 256'(0));
      chk("csr_hit", 256'(fch_a), 256'(1));
      chk("csr_data", 256'(fcd_a), 256'(32'hABCD));

      // FLUSH of a full queue with a simultaneous enqueue
      fwd_reg_addr = 5'd3; fwd_csr_addr = 12'h301;
      exec_valid = 1;
      for (int i = 0; i < 4; i++) begin
         rand_ent(); cur.reg_w_en = 1; cur.rd = 5'd3; cur.csr_en = 1; cur.caddr = 12'h301;
         tick();
      end
      flush = 1; rand_ent(); tick(); flush = 0; exec_valid = 0;
      chk("flush_count", 256'(count_a), 256'(0));
      chk("flush_valid", 256'(out_valid_a), 256'(0));
      chk("flush_hits", 256'({frh_a, frb_a, fch_a}), 256'(0));

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         rand_ent();
         exec_valid   = ($urandom_range(0, 9) < 7);
         mem_wait     = ($urandom_range(0, 9) < 4);
         flush        = ($urandom_range(0, 31) == 0);
         fwd_reg_addr = 5'($urandom_range(0, 7));
         fwd_csr_addr = 12'h300 + 12'($urandom_range(0, 3));
         tick();
      end
      flush = 0;

      // Asynchronous reset mid-drain
      mem_wait = 1; exec_valid = 1;
      for (int i = 0; i < 3; i++) begin
         rand_ent(); cur.reg_w_en = 1; cur.rd = 5'd6; cur.ld_en = 0; tick();
      end
      exec_valid = 0; mem_wait = 0; fwd_reg_addr = 5'd6;
      tick();
      #2; rst = 1; #1;
      qa.delete(); qb.delete();
      chk("arst_count", 256'(count_a), 256'(0));
      chk("arst_out_valid", 256'(out_valid_a), 256'(0));
      chk("arst_in_ready", 256'(in_ready_a), 256'(1));
      chk("arst_head", 256'(hd_a), 256'(0));
      chk("arst_fwd", 256'({frh_a, frb_a, frd_a}), 256'(0));
      check_all();
      #2; rst = 0;
      for (int i = 0; i < 20; i++) begin
         rand_ent();
         exec_valid = 1'($urandom);
         mem_wait   = 1'($urandom);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/exec_queue.md
# exec_queue

Parametrised, DEPTH-entry in-order queue between the execute stage and the memory-read stage of the core. It generalises the single-register execute-wait stage. It absorbs up to DEPTH execute results while MEM_WAIT is asserted instead of stalling the whole front end. It also provides newest-first register and CSR forwarding across every buffered entry, with load-pending detection.

## Interface
- DEPTH, 4, number of entries (≥1; need not be a power of two)
- PW, 145, width of opaque payload (mem-read addr/strb/signed, mem-write en/addr/strb/data, jmp do/pc)
- CLK  in  1  clock
- RST  in  1  asynchronous, active-high reset
- FLUSH  in  1  synchronous clear of all entries
- MEM_WAIT  in  1  downstream hold; blocks dequeue only
- EXEC_VALID  in  1  execute result present
- IN_READY  out  1  queue can accept (= count < DEPTH)
- EXEC_REG_W_EN / EXEC_REG_W_RD / EXEC_REG_W_DATA  in  1/5/32  integer register write
- EXEC_CSR_W_EN / EXEC_CSR_W_ADDR / EXEC_CSR_W_DATA  in  1/12/32  CSR write
- EXEC_MEM_R_EN / EXEC_MEM_R_RD  in  1/5  load and its destination
- EXEC_PAYLOAD  in  PW  remaining fields, carried untouched
- OUT_VALID  out  1  head entry valid
- Q_REG_W_EN … Q_PAYLOAD  out  as inputs  head entry fields
- COUNT  out  $clog2(DEPTH+1)  occupancy
- FWD_REG_ADDR  in  5 ; FWD_REG_HIT  out 1 ; FWD_REG_BUSY  out 1 ; FWD_REG_DATA  out 32
- FWD_CSR_ADDR  in  12 ; FWD_CSR_HIT  out 1 ; FWD_CSR_DATA  out 32

## Operation
- Enqueue when EXEC_VALID && IN_READY && !FLUSH, at the tail; MEM_WAIT does not block enqueue.
- Dequeue when OUT_VALID && !MEM_WAIT && !FLUSH. The head advances and its fields are consumed that edge.
- Simultaneous enqueue and dequeue: COUNT unchanged, both pointers advance.
- Full: IN_READY=0 even if a dequeue occurs that cycle (no pass-through). Upstream stalls.
- Empty: OUT_VALID=0, Q_* outputs driven 0 (enables masked).
- Pointers wrap from DEPTH-1 to 0 explicitly; there is no power-of-two assumption.
- FLUSH has top priority. Next edge: COUNT=0, pointers 0, all valid bits clear, and any same-cycle enqueue is dropped.
- Register forwarding: among valid entries, the newest with (REG_W_EN && RD==addr) or (MEM_R_EN && MEM_R_RD==addr) wins.
  - If the winner is a register write: HIT=1, DATA=its data.
  - If the winner is a load: BUSY=1, HIT=0.
  - addr==0 always gives HIT=BUSY=0, DATA=0.
- CSR forwarding: newest valid entry with CSR_W_EN && addr match gives HIT=1, DATA; otherwise 0.
- Forwarding is combinational from stored entries only. The same-cycle EXEC_* input is not searched.

## Timing
- Reset values: COUNT=0, OUT_VALID=0, IN_READY=1, all Q_*/FWD_* outputs 0, pointers 0.
- Latency from enqueue into an empty queue to OUT_VALID is 1 cycle.
- Head fields are stable while MEM_WAIT=1.
- An asynchronous reset mid-operation discards every entry immediately. Payload RAM contents need not be cleared; only valid bits and pointers reset.

## Structure
- The shared core package holds the payload field offsets and widths (PW composition) and the constant for register x0.
- One natural sub-module is exec_queue_lookup: a combinational newest-first priority search. It takes entry valid/enable/address vectors plus head pointer and COUNT, and returns hit/busy/index. It is instantiated twice (reg, CSR).

## Test plan
- Fill and drain: DEPTH=4, 4 back-to-back enqueues with MEM_WAIT=1.
  - Expect COUNT=4 and IN_READY=0; a 5th EXEC_VALID is not accepted.
  - Release MEM_WAIT: entries exit in order over 4 cycles and COUNT returns to 0.
- Wrap-around: DEPTH=3, 7 enqueues interleaved with dequeues. Expect the data sequence preserved with no loss or duplication.
- Forwarding priority: enqueue x5←0x11, then x5←0x22. Expect FWD_REG_ADDR=5 to give HIT=1, DATA=0x22. Then enqueue a load to x5 and expect BUSY=1, HIT=0.
- x0 and CSR: enqueue REG_W_RD=0 data 0xFF and CSR 0x300←0xABCD. Expect FWD_REG_ADDR=0 to give HIT=0, and FWD_CSR_ADDR=0x300 to give HIT=1, DATA=0xABCD.
- FLUSH with full queue plus a simultaneous EXEC_VALID. Next cycle expect COUNT=0, OUT_VALID=0, all FWD hits 0.
- Assert RST asynchronously mid-drain. Expect outputs at reset values immediately, without waiting for a CLK edge.
